eem16_coin_front: RTL and testbench

Coin-slot front end for the eem16_proj3 vending FSM. Synchronizes and debounces the raw nickel/dime sensor lines, turns each debounced insertion into one coin event, and buffers events in a small FIFO. It drains them to the FSM's `x[1:0]` input as one-cycle coin codes. Overflow and both-coins-at-once conditions are flagged so the coin return can reject them.

---
 rtl/eem16_coin_front.sv | 138 +++++++++++++
 tb/tb_eem16_coin_front.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eem16_coin_front.sv
// eem16_coin_front: coin-slot front end for the eem16_proj3 vending FSM.
// It synchronizes and debounces the raw nickel and dime sensor lines, turns
// each debounced rising edge into one coin event, and queues the events in a
// small FIFO. The FIFO drains to x as one-cycle coin codes.
//
// Build option: define EEM16_COIN_GAP_EN to insert one idle x cycle after
// every coin code, which halves the drain rate.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; clears all state
//   nickel_in  raw nickel sensor (asynchronous)
//   dime_in    raw dime sensor (asynchronous)
//   hold       1: no pop this cycle, and x goes to 00
//   x          coin code to the FSM: 00 none, 01 nickel, 11 dime
//   coin_rej   one-cycle pulse when an event is dropped on a full FIFO
//   jam        one-cycle pulse when both debounced lines rise together
//   count      number of queued events
module eem16_coin_front #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             nickel_in,
  input  logic                             dime_in,
  input  logic                             hold,
  output logic [1:0]                       x,
  output logic                             coin_rej,
  output logic                             jam,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);

  localparam int unsigned CW = 4;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);

  // Bit 0 carries the nickel line and bit 1 carries the dime line.
  logic [1:0]    sync1;
  logic [1:0]    s;
  logic [1:0]    db;
  logic [1:0]    db_q;
  logic [CW-1:0] cnt [2];

  logic [1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [1:0]    rise_c;
  logic          ev_valid_c;
  logic [1:0]    ev_code_c;
  logic          jam_c;
  logic          pop_c;
  logic          push_c;
  logic          rej_c;

  // Two-flop synchronizer, plus a delayed copy of db for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      s     <= '0;
      db_q  <= '0;
    end else begin
      sync1 <= {dime_in, nickel_in};
      s     <= sync1;
      db_q  <= db;
    end
  end

  // Debounce: db toggles after DEBOUNCE_CYCLES consecutive samples that differ from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s[i] != db[i]) begin
          if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            db[i]  <= ~db[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Event detect: a rise on exactly one line is a coin; a rise on both lines is a jam.
  always_comb begin
    rise_c     = db & ~db_q;
    jam_c      = &rise_c;
    ev_valid_c = ^rise_c;
    ev_code_c  = rise_c[1] ? 2'b11 : 2'b01;
  end

`ifdef EEM16_COIN_GAP_EN
  // A pop is allowed only after an idle x cycle.
  assign pop_c = !hold && (count != '0) && (x == 2'b00);
`else
  assign pop_c = !hold && (count != '0);
`endif

  // A full FIFO still accepts an event when an entry is popped in the same cycle.
  assign push_c = ev_valid_c && ((count != NW'(FIFO_DEPTH)) || pop_c);
  assign rej_c  = ev_valid_c && !push_c;

  // FIFO storage. Empty and full are decided by count, so the entries need no reset.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= ev_code_c;
  end

  // Pointers, occupancy, and the registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      x        <= 2'b00;
      coin_rej <= 1'b0;
      jam      <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
      x        <= pop_c ? mem[rd_ptr] : 2'b00;
      coin_rej <= rej_c;
      jam      <= jam_c;
    end
  end

endmodule

// File: tb/tb_eem16_coin_front.sv
// Directed testbench for eem16_coin_front. It uses the default parameters
// (DEBOUNCE_CYCLES = 4, FIFO_DEPTH = 4). Inputs change on the falling edge,
// and outputs are sampled on the falling edge.
module tb_eem16_coin_front;

  logic       clk;
  logic       reset;
  logic       nickel_in;
  logic       dime_in;
  logic       hold;
  logic [1:0] x;
  logic       coin_rej;
  logic       jam;
  logic [2:0] count;

  int checks;
  int errors;
  int x_seen;
  int rej_seen;
  int jam_seen;

  eem16_coin_front dut (
    .clk       (clk),
    .reset     (reset),
    .nickel_in (nickel_in),
    .dime_in   (dime_in),
    .hold      (hold),
    .x         (x),
    .coin_rej  (coin_rej),
    .jam       (jam),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one coin (hi cycles high, lo cycles low) and tally the output pulses.
  task automatic drive_coin(input logic n, input logic d, input int hi, input int lo);
    nickel_in = n;
    dime_in   = d;
    for (int i = 0; i < hi + lo; i++) begin
      if (i == hi) begin
        nickel_in = 1'b0;
        dime_in   = 1'b0;
      end
      @(negedge clk);
      if (x != 2'b00) x_seen++;
      if (coin_rej)   rej_seen++;
      if (jam)        jam_seen++;
    end
  endtask

  task automatic clear_tally();
    x_seen   = 0;
    rej_seen = 0;
    jam_seen = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; nickel_in = 1'b0; dime_in = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (x !== 2'b00 || coin_rej !== 1'b0 || jam !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset: x=%b rej=%b jam=%b count=%0d, want 00 0 0 0", x, coin_rej, jam, count);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One nickel: x shows 01 only after edge k+7, and count is 1 only after edge k+6.
  task automatic test_single_nickel();
    logic [1:0] ex;
    logic [2:0] ec;
    nickel_in = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i == 10) nickel_in = 1'b0;
      @(negedge clk);
      ex = (i == 7) ? 2'b01 : 2'b00;
      ec = (i == 6) ? 3'd1 : 3'd0;
      checks++;
      if (x !== ex || count !== ec) begin
        errors++;
        $display("FAIL nickel_latency edge k+%0d: x=%b count=%0d, want x=%b count=%0d", i, x, count, ex, ec);
      end
    end
  endtask

  task automatic test_glitch();
    clear_tally();
    drive_coin(1'b0, 1'b1, 3, 15);
    checks++;
    if (x_seen != 0 || rej_seen != 0 || jam_seen != 0 || count !== 3'd0) begin
      errors++;
      $display("FAIL glitch: x_seen=%0d rej=%0d jam=%0d count=%0d, want 0 0 0 0", x_seen, rej_seen, jam_seen, count);
    end
  endtask

  // Both lines rise together: jam pulses once, exactly after edge k+6, and nothing is queued.
  task automatic test_jam();
    logic ej;
    nickel_in = 1'b1;
    dime_in   = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i == 8) begin
        nickel_in = 1'b0;
        dime_in   = 1'b0;
      end
      @(negedge clk);
      ej = (i == 6);
      checks++;
      if (jam !== ej || x !== 2'b00 || count !== 3'd0) begin
        errors++;
        $display("FAIL jam edge k+%0d: jam=%b x=%b count=%0d, want jam=%b x=00 count=0", i, jam, x, count, ej);
      end
    end
  endtask

  task automatic test_overflow();
    logic [1:0] exp_seq [8];
    hold = 1'b1;
    for (int c = 0; c < 5; c++) begin
      clear_tally();
      drive_coin(1'b1, 1'b0, 8, 8);
      checks++;
      if (count !== 3'((c < 4) ? c + 1 : 4) || rej_seen != ((c == 4) ? 1 : 0) || x_seen != 0) begin
        errors++;
        $display("FAIL overflow coin %0d: count=%0d rej=%0d x_seen=%0d, want count=%0d rej=%0d x_seen=0",
                 c, count, rej_seen, x_seen, (c < 4) ? c + 1 : 4, (c == 4) ? 1 : 0);
      end
    end
`ifdef EEM16_COIN_GAP_EN
    exp_seq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
`else
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
`endif
    hold = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (x !== exp_seq[i]) begin
        errors++;
        $display("FAIL overflow_drain cycle %0d: x=%b, want %b", i, x, exp_seq[i]);
      end
    end
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL overflow_drain count: count=%0d, want 0", count);
    end
  endtask

  task automatic test_reset_flush();
    hold = 1'b1;
    for (int c = 0; c < 3; c++) drive_coin(1'b0, 1'b1, 8, 8);
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL flush_fill: count=%0d, want 3", count);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (x !== 2'b00 || count !== 3'd0) begin
      errors++;
      $display("FAIL flush_async: x=%b count=%0d, want 00 0", x, count);
    end
    @(negedge clk);
    reset = 1'b0;
    hold  = 1'b0;
    clear_tally();
    drive_coin(1'b0, 1'b0, 0, 12);
    checks++;
    if (x_seen != 0 || count !== 3'd0) begin
      errors++;
      $display("FAIL flush_after: x_seen=%0d count=%0d, want 0 0", x_seen, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_seq [4];
    hold = 1'b1;
    drive_coin(1'b0, 1'b1, 8, 8);
    drive_coin(1'b0, 1'b1, 8, 8);
`ifdef EEM16_COIN_GAP_EN
    exp_seq = '{2'b11, 2'b00, 2'b11, 2'b00};
`else
    exp_seq = '{2'b11, 2'b11, 2'b00, 2'b00};
`endif
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (x !== exp_seq[i]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: x=%b, want %b", i, x, exp_seq[i]);
      end
    end
  endtask

  // Mixed coins queued under hold; the pointers wrap past the end of the FIFO.
  task automatic test_order_wrap();
    logic [1:0] exp_seq [6];
    hold = 1'b1;
    drive_coin(1'b1, 1'b0, 8, 8);
    drive_coin(1'b0, 1'b1, 8, 8);
    drive_coin(1'b1, 1'b0, 8, 8);
`ifdef EEM16_COIN_GAP_EN
    exp_seq = '{2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00};
`else
    exp_seq = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00};
`endif
    hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (x !== exp_seq[i]) begin
        errors++;
        $display("FAIL order_wrap cycle %0d: x=%b, want %b", i, x, exp_seq[i]);
      end
    end
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL order_wrap count: count=%0d, want 0", count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_tally();
    test_reset();
    test_single_nickel();
    test_glitch();
    test_jam();
    test_overflow();
    test_reset_flush();
    test_back_to_back();
    test_order_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
